// File: rtl/rolha_pkg.sv
// Shared types and default constants for the cork feeder block.
package rolha_pkg;

    localparam int unsigned RolhaBatch  = 15;
    localparam int unsigned RolhaStockW = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StXfer    = 3'd1,
        StDone    = 3'd2,
        StWaitRel = 3'd3,
        StEmpty   = 3'd4
    } rolha_state_e;

endpackage

// File: rtl/rolha_stock_cnt.sv
// Warehouse stock holder: loadable down-counter with a zero flag.
module rolha_stock_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/rolha_feeder.sv
// Cork feeder: answers dispenser refill requests with a batch of cork pulses.
// Optional registered low-stock warning enabled by ROLHA_FEEDER_LOW_STOCK_EN.
module rolha_feeder
    import rolha_pkg::*;
#(
    parameter int unsigned BATCH   = RolhaBatch,
    parameter int unsigned STOCK_W = RolhaStockW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               load_stock,
    input  logic [STOCK_W-1:0] stock_in,
    output logic               cork_pulse,
    output logic               ack,
    output logic               busy,
    output logic [3:0]         delivered,
    output logic [STOCK_W-1:0] stock,
    output logic               alarme,
    output logic               low_stock
);

    rolha_state_e state_q, state_d;
    logic [3:0]   delivered_q, delivered_d;
    logic [3:0]   batch_len_q, batch_len_d;
    logic         stock_load, stock_dec, stock_zero;

    rolha_stock_cnt #(
        .Width (STOCK_W)
    ) u_stock_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (stock_load),
        .load_val_i (stock_in),
        .dec_i      (stock_dec),
        .count_o    (stock),
        .zero_o     (stock_zero)
    );

    always_comb begin
        state_d     = state_q;
        delivered_d = delivered_q;
        batch_len_d = batch_len_q;
        stock_load  = 1'b0;
        stock_dec   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_stock) begin
                    stock_load = 1'b1;
                end else if (req && !stock_zero) begin
                    batch_len_d = (32'(stock) < BATCH) ? stock[3:0] : 4'(BATCH);
                    delivered_d = '0;
                    state_d     = StXfer;
                end else if (req) begin
                    state_d = StEmpty;
                end
            end
            StXfer: begin
                stock_dec   = 1'b1;
                delivered_d = delivered_q + 4'd1;
                if (delivered_q == 4'(batch_len_q - 4'd1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StWaitRel;
            end
            StWaitRel: begin
                stock_load = load_stock;
                // One long request must never yield a second batch.
                if (!req) begin
                    state_d     = StIdle;
                    delivered_d = '0;
                end
            end
            StEmpty: begin
                if (load_stock && (stock_in != '0)) begin
                    stock_load = 1'b1;
                    state_d    = StIdle;
                end else if (!req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            delivered_q <= '0;
            batch_len_q <= '0;
        end else begin
            state_q     <= state_d;
            delivered_q <= delivered_d;
            batch_len_q <= batch_len_d;
        end
    end

    assign cork_pulse = (state_q == StXfer);
    assign ack        = (state_q == StDone);
    assign busy       = (state_q == StXfer) || (state_q == StDone);
    assign alarme     = (state_q == StEmpty);
    assign delivered  = delivered_q;

`ifdef ROLHA_FEEDER_LOW_STOCK_EN
    logic               low_stock_q;
    logic [STOCK_W-1:0] stock_next;

    // Mirrors the counter's next value so the flag moves on the same edge as stock.
    always_comb begin
        stock_next = stock;
        if (stock_load) begin
            stock_next = stock_in;
        end else if (stock_dec && !stock_zero) begin
            stock_next = stock - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            low_stock_q <= 1'b0;
        end else begin
            low_stock_q <= (32'(stock_next) < BATCH) && (state_d != StEmpty);
        end
    end

    assign low_stock = low_stock_q;
`else
    assign low_stock = 1'b0;
`endif

endmodule

// File: doc/rolha_feeder.md
# rolha_feeder

Warehouse-side cork supplier. It answers refill requests from the cork dispenser FSM by delivering a batch of corks, one per clock, from an internal warehouse stock counter. It then acknowledges completion and raises an alarm when the stock is exhausted. It sits between the operator stock-load inputs and the dispenser's `add_rolha` request line, and is the responder end of the dispenser refill handshake.

## Interface
- `BATCH`, default 15: maximum corks delivered per request (1..15).
- `STOCK_W`, default 8: width of the warehouse stock counter.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  refill request from the dispenser (level, driven by `add_rolha`).
- `load_stock`  in  1  operator strobe; loads `stock_in` into the stock counter.
- `stock_in`  in  STOCK_W  new warehouse stock value.
- `cork_pulse`  out  1  high for one cycle per cork delivered.
- `ack`  out  1  one-cycle pulse when a batch completes.
- `busy`  out  1  high while a batch is being delivered (XFER) or being acknowledged (DONE).
- `delivered`  out  4  number of corks delivered so far in the current batch.
- `stock`  out  STOCK_W  current warehouse stock.
- `alarme`  out  1  high while in EMPTY (request pending, stock is zero).
- `low_stock`  out  1  low-stock warning (see Configuration).

## Operation
- States: IDLE, XFER, DONE, WAIT_REL, EMPTY.
- **IDLE**
  - If `load_stock` is high: `stock <= stock_in` and the state stays IDLE. Load has priority over `req` in the same cycle; `req` is re-evaluated on the next cycle.
  - Else if `req` is high and `stock != 0`: latch `batch_len = min(BATCH, stock)`, clear `delivered`, go to XFER.
  - Else if `req` is high and `stock == 0`: go to EMPTY.
- **XFER**
  - Each cycle: `cork_pulse = 1`, `stock <= stock - 1`, `delivered <= delivered + 1`.
  - In the cycle where `delivered == batch_len - 1`, go to DONE.
  - `load_stock` is ignored in this state.
  - `req` falling mid-batch does not abort the batch; the batch always completes.
- **DONE**
  - `ack = 1` for exactly one cycle.
  - `delivered` holds the final count.
  - Next state is WAIT_REL.
- **WAIT_REL**
  - Stay while `req` is high. This prevents a second batch from one long request.
  - On `req` low, go to IDLE and clear `delivered`.
  - `load_stock` is honoured here.
- **EMPTY**
  - `alarme = 1`.
  - If `load_stock` is high and `stock_in != 0`: load the stock and go to IDLE.
  - If `req` drops: go to IDLE.
  - A load of 0 keeps the block in EMPTY.
- Arithmetic:
  - `stock` never decrements below 0, because `batch_len` is never larger than `stock`.
  - `delivered` never exceeds `BATCH`.
  - `batch_len` is computed as an unsigned comparison of `stock` against `BATCH`.
- All outputs are Moore, decoded from the state register and counters.

## Timing
- Reset values: state IDLE, `stock = 0`, `delivered = 0`, `cork_pulse = 0`, `ack = 0`, `busy = 0`, `alarme = 0`, `low_stock = 0`.
- Reset in any state, including mid-XFER, clears everything on the next edge. Partially delivered corks are not restored to `stock`.
- Request to first cork: `req` is sampled high at edge N, so `cork_pulse` is high during cycle N+1.
- A batch of k corks gives k consecutive `cork_pulse` cycles, then the `ack` cycle. Total time from request to `ack` is k+1 cycles.
- `busy` rises together with the first `cork_pulse` and falls after the `ack` cycle.
- Minimum time from one `ack` to the next batch: 1 cycle with `req` low (in WAIT_REL), then 1 cycle in IDLE.

## Configuration
- Macro `ROLHA_FEEDER_LOW_STOCK_EN`.
- Defined: `low_stock` is registered high whenever `stock < BATCH` and the state is not EMPTY. It updates on the same edge as `stock`.
- Undefined: `low_stock` is tied to 0. The port remains present so that integration is unchanged either way.

## Structure
- Shared package `rolha_pkg`:
  - state encoding typedef (IDLE=0, XFER=1, DONE=2, WAIT_REL=3, EMPTY=4, 3 bits),
  - default `BATCH` constant 15,
  - `STOCK_W` constant 8.
- One sub-module, `rolha_stock_cnt`: a loadable down-counter with a zero flag, holding the warehouse stock. The FSM and batch counter stay in the top module.

## Test plan
- Reset, then `load_stock` with `stock_in = 40`, then `req` held high: 15 `cork_pulse` cycles, `stock = 25`, one `ack`, `delivered = 15`. `busy` is high for 16 cycles.
- `stock = 7`, `req` high: exactly 7 pulses, `ack`, `stock = 0`. With the macro defined, `low_stock = 1`.
- `stock = 0`, `req` high: `alarme = 1` with no pulses. `load_stock` with `stock_in = 20` clears `alarme`, and the block returns to IDLE; `req` still high then starts a 15-cork batch.
- `req` held high for 40 cycles after `ack`: no second batch. Dropping `req` for 1 cycle and then raising it starts a new batch.
- `reset` asserted after 5 pulses of a 15-cork batch: the next cycle shows all outputs at their reset values and `stock = 0`.
- `load_stock` and `req` both high in IDLE with `stock_in = 3`: the load is taken, the first pulse comes two cycles later, and exactly 3 pulses are delivered.
